// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps {a,b,c} through 0..7 with a dwell, captures d into an 8-bit table; SWEEP_CHECK_EN adds the checker
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       d,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] mismatch_count,
  output logic       pass
);
  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_table;
  logic w_sample, w_go;
  assign w_sample = r_state == DWELL && r_cnt == LAST;
  assign w_go = r_state == IDLE && start;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? DWELL : IDLE) :
             r_state == DONE ? IDLE :
             abort ? IDLE :
             (w_sample && r_idx == 3'd7) ? DONE : DWELL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_table <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_cnt   <= '0;
        r_idx   <= '0;
        r_table <= '0;
      end else if (r_state == DWELL) begin
        r_cnt <= w_sample ? 8'd0 : r_cnt + 8'd1;
        if (w_sample) begin
          r_table[r_idx] <= d;
          if (r_idx != 3'd7) r_idx <= r_idx + 3'd1;
        end
      end
    end
  end
  assign {a, b, c} = r_state == DWELL ? r_idx : 3'b000;
  assign busy = r_state == DWELL;
  assign done = r_state == DONE;
  assign table_out = r_table;
`ifdef SWEEP_CHECK_EN
  logic [3:0] r_mm;
  logic r_pass, w_miss;
  logic [3:0] w_mm_next;
  assign w_miss = d != EXPECTED[r_idx];
  assign w_mm_next = r_mm + {3'b000, w_miss};
  always_ff @(posedge clk) begin
    if (rst || w_go) begin
      r_mm   <= '0;
      r_pass <= 1'b0;
    end else if (w_sample) begin
      r_mm <= w_mm_next;
      if (r_idx == 3'd7 && !abort) r_pass <= w_mm_next == 4'd0;
    end
  end
  assign mismatch_count = r_mm;
  assign pass = r_pass;
`else
  // constant zero that still references EXPECTED so the parameter is not flagged as unused
  assign mismatch_count = 4'd0;
  assign pass = &{1'b0, EXPECTED};
`endif
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that drives the three inputs of a 3-input combinational boolean block (a, b, c → d) through all eight input combinations. It holds each combination for a programmable dwell time, samples d, and assembles an 8-bit truth table. An optional checker compares the table against an expected constant. It replaces fixed-delay testbench stimulus with a synthesizable, start/done-controlled sweep for on-board self-test of the boolean_* blocks.

## Interface
- SETTLE_CYCLES, 4, clock cycles each input vector is held before d is sampled; legal range 1..255
- EXPECTED, 8'h00, expected truth table; bit k = d for vector k
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  begin a sweep; accepted only in IDLE
- abort  input  1  cancel an active sweep; returns to IDLE without done
- d  input  1  output of the block under control
- a  output  1  vector bit 2 (MSB)
- b  output  1  vector bit 1
- c  output  1  vector bit 0 (LSB)
- busy  output  1  high while a sweep is in progress
- done  output  1  single-cycle pulse when a sweep completes
- table_out  output  8  captured truth table; bit k = d sampled with {a,b,c}=k
- mismatch_count  output  4  number of bits where table_out differs from EXPECTED (0..8)
- pass  output  1  high when mismatch_count==0 after a completed sweep

## Operation
- FSM states: IDLE, DWELL, DONE.
- IDLE: {a,b,c}=000, busy=0. start=1 → clear table_out and mismatch_count, vector index idx=0, dwell counter cnt=0, go to DWELL.
- DWELL: {a,b,c}=idx, busy=1. cnt increments each cycle. When cnt==SETTLE_CYCLES-1, the block writes d into table_out[idx] and resets cnt to 0.
  - If idx<7: idx increments.
  - If idx==7: go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; {a,b,c} returns to 000; go to IDLE.
- table_out, mismatch_count and pass hold their values until the next accepted start or reset.
- start while in DWELL or DONE is ignored; it is not queued.
- abort=1 in DWELL → IDLE on the next edge. No done pulse. table_out keeps its partial contents, pass=0.
- abort and start high together in IDLE: start wins, because abort has no effect in IDLE.
- Counter widths: cnt is 8 bits. idx is 3 bits and never wraps past 7.

## Timing
- Reset values: a=b=c=0, busy=0, done=0, table_out=8'h00, mismatch_count=0, pass=0; state IDLE.
- rst mid-sweep forces the reset values on the next edge. No done pulse is produced.
- start is sampled at edge E0.
  - Vector k is visible on a,b,c from edge E0+k·S to edge E0+(k+1)·S, where S=SETTLE_CYCLES.
  - d is sampled at edge E0+(k+1)·S.
- busy rises after E0 and falls after E0+8S.
- done is high in the cycle following edge E0+8S.
- Total latency from start to done = 8S+1 cycles.
- d must be stable in the cycle before its sample edge. The block adds no synchronizer.
- pass and mismatch_count are valid in the same cycle as done.

## Configuration
- Macro SWEEP_CHECK_EN.
- Defined: the checker is present. mismatch_count accumulates one per sampled bit ≠ EXPECTED[idx]. pass=1 in DONE and holds afterwards iff mismatch_count==0.
- Undefined: no checker logic. mismatch_count is tied to 0 and pass is tied to 0. EXPECTED is unused.
- Sequencing and table_out behave the same in both builds.

## Test plan
- XOR model d=a^b^c, S=4, EXPECTED=8'h96, start pulse → vectors 000..111 each held 4 cycles; done 33 cycles after start; table_out=8'h96, mismatch_count=0, pass=1.
- AND model d=a&b&c, S=4, EXPECTED=8'h96 → table_out=8'h80, mismatch_count=3, pass=0.
- S=1, XOR model → vector changes every cycle; done 9 cycles after start; table_out=8'h96.
- start re-pulsed during DWELL at idx=3 → ignored; a single done, timing unchanged. Then rst asserted at idx=5 → all outputs at reset values on the next edge, no done.
- abort at idx=2 with S=4 → busy=0 next cycle, no done; table_out bits 1:0 captured, bits 7:2 =0, pass=0. A new start then completes normally.
- Build without SWEEP_CHECK_EN, XOR model → table_out=8'h96, mismatch_count=0, pass=0.
